// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
// Used by multicycle_ctrl and instr_decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLT = 3'b101
  } alu_op_t;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    BRANCH,
    WRITEBACK,
    ILLEGAL
  } ctrl_state_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational instruction classifier for the multi-cycle controller.
// Maps the latched IR to an ALU op plus class and legality flags.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output alu_op_t     alu_op,
  output logic        is_r,
  output logic        is_i,
  output logic        is_branch,
  output logic        is_bne,
  output logic        is_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       funct_ok;
  logic       unused_fields;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  // Register specifiers and immediates are consumed by the datapath, not here.
  assign unused_fields = ^{ir[24:15], ir[11:7]};

  always_comb begin
    alu_op     = ADD;
    funct_ok   = 1'b0;
    is_r       = (opcode == OP_R);
    is_i       = (opcode == OP_I);
    is_branch  = (opcode == OP_B) && ((funct3 == F3_BEQ) || (funct3 == F3_BNE));
    is_bne     = is_branch && (funct3 == F3_BNE);
    is_illegal = 1'b1;

    if (is_r) begin
      case (funct3)
        F3_ADDSUB: begin
          if (funct7 == F7_BASE) begin
            alu_op   = ADD;
            funct_ok = 1'b1;
          end else if (funct7 == F7_SUB) begin
            alu_op   = SUB;
            funct_ok = 1'b1;
          end
        end
        F3_AND: begin
          alu_op   = AND;
          funct_ok = (funct7 == F7_BASE);
        end
        F3_OR: begin
          alu_op   = OR;
          funct_ok = (funct7 == F7_BASE);
        end
        F3_SLT: begin
          alu_op   = SLT;
          funct_ok = (funct7 == F7_BASE);
        end
        default: funct_ok = 1'b0;
      endcase
    end else if (is_i) begin
      funct_ok = 1'b1;
      case (funct3)
        F3_ADDSUB: alu_op = ADD;
        F3_AND:    alu_op = AND;
        F3_OR:     alu_op = OR;
        F3_SLT:    alu_op = SLT;
        default:   funct_ok = 1'b0;
      endcase
    end

    is_illegal = !(((is_r || is_i) && funct_ok) || is_branch);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the Lab-4 RISC-V ALU datapath.
// Define MULTICYCLE_CTRL_RETIRE_CNT_EN to add the retire_cnt output.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic                   EQ,
  output logic [2:0]             ALUctrl,
  output logic                   ALUsrc,
  output logic [1:0]             ImmSrc,
  output logic                   RegWrite,
  output logic                   PCsrc,
  output logic                   PCen,
  output logic                   illegal
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   retire_cnt
`endif
);

  if (INSTR_WIDTH != 32 || CNT_WIDTH < 1) begin : g_bad_param
    $error("multicycle_ctrl: INSTR_WIDTH must be 32 and CNT_WIDTH at least 1");
  end

  ctrl_state_t            state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   illegal_q, illegal_d;

  alu_op_t dec_alu_op;
  logic    dec_is_r, dec_is_i, dec_is_branch, dec_is_bne, dec_is_illegal;

  instr_decoder u_decoder (
    .ir         (ir_q),
    .alu_op     (dec_alu_op),
    .is_r       (dec_is_r),
    .is_i       (dec_is_i),
    .is_branch  (dec_is_branch),
    .is_bne     (dec_is_bne),
    .is_illegal (dec_is_illegal)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_is_illegal) begin
          state_d   = ILLEGAL;
          illegal_d = 1'b1;
        end else if (dec_is_branch) begin
          state_d = BRANCH;
        end else if (dec_is_r || dec_is_i) begin
          state_d = EXECUTE;
        end else begin
          state_d   = ILLEGAL;
          illegal_d = 1'b1;
        end
      end
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: state_d = FETCH;
      BRANCH:    state_d = FETCH;
      ILLEGAL:   state_d = ILLEGAL;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore outputs; rst forces everything low so a reset edge never commits a write.
  always_comb begin
    instr_ready = 1'b0;
    ALUctrl     = ADD;
    ALUsrc      = 1'b0;
    ImmSrc      = IMM_I;
    RegWrite    = 1'b0;
    PCsrc       = 1'b0;
    PCen        = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      illegal = illegal_q;
      case (state_q)
        FETCH: instr_ready = 1'b1;
        EXECUTE: begin
          ALUctrl = dec_alu_op;
          ALUsrc  = dec_is_i;
        end
        WRITEBACK: begin
          ALUctrl  = dec_alu_op;
          ALUsrc   = dec_is_i;
          RegWrite = 1'b1;
          PCen     = 1'b1;
        end
        BRANCH: begin
          ALUctrl = SUB;
          ImmSrc  = IMM_B;
          PCen    = 1'b1;
          PCsrc   = dec_is_bne ? ~EQ : EQ;
        end
        ILLEGAL: illegal = 1'b1;
        default: instr_ready = 1'b0;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] retire_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else if (PCen) begin
      retire_cnt_q <= retire_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Define MULTICYCLE_CTRL_RETIRE_CNT_EN to also check retire_cnt.
module tb_multicycle_ctrl;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_OR   = 32'h003160B3;
  localparam logic [31:0] I_SLTI = 32'h0051A093;
  localparam logic [31:0] I_ANDI = 32'h0051F093;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        EQ;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic [1:0]  ImmSrc;
  logic        RegWrite;
  logic        PCsrc;
  logic        PCen;
  logic        illegal;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int testCount = 0;
  int failCount = 0;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .EQ          (EQ),
    .ALUctrl     (ALUctrl),
    .ALUsrc      (ALUsrc),
    .ImmSrc      (ImmSrc),
    .RegWrite    (RegWrite),
    .PCsrc       (PCsrc),
    .PCen        (PCen),
    .illegal     (illegal)
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic vld, input logic eq);
    instr       = ins;
    instr_valid = vld;
    EQ          = eq;
  endtask

  // Advance to just after the falling edge, where outputs are stable.
  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic ready, input logic [2:0] alu,
                          input logic src, input logic [1:0] imm, input logic rw,
                          input logic pcs, input logic pce, input logic ill);
    checkOutput({tag, ".instr_ready"}, 32'(instr_ready), 32'(ready));
    checkOutput({tag, ".ALUctrl"},     32'(ALUctrl),     32'(alu));
    checkOutput({tag, ".ALUsrc"},      32'(ALUsrc),      32'(src));
    checkOutput({tag, ".ImmSrc"},      32'(ImmSrc),      32'(imm));
    checkOutput({tag, ".RegWrite"},    32'(RegWrite),    32'(rw));
    checkOutput({tag, ".PCsrc"},       32'(PCsrc),       32'(pcs));
    checkOutput({tag, ".PCen"},        32'(PCen),        32'(pce));
    checkOutput({tag, ".illegal"},     32'(illegal),     32'(ill));
  endtask

  // Entered and left in FETCH. A junk word offered during DECODE must be ignored.
  task automatic runAlu(input string tag, input logic [31:0] ins, input logic [2:0] op, input logic src);
    applyStimulus(ins, 1'b1, 1'b0);
    nextCycle();
    checkAll({tag, ".dec"}, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(I_BAD, 1'b1, 1'b0);
    nextCycle();
    checkAll({tag, ".exe"}, 1'b0, op, src, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkAll({tag, ".wb"}, 1'b0, op, src, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b0);
    nextCycle();
    checkAll({tag, ".fetch"}, 1'b1, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic runBranch(input string tag, input logic [31:0] ins, input logic eq, input logic expPcsrc);
    applyStimulus(ins, 1'b1, eq);
    nextCycle();
    checkAll({tag, ".dec"}, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0, 1'b0, eq);
    nextCycle();
    checkAll({tag, ".br"}, 1'b0, 3'b001, 1'b0, 2'b10, 1'b0, expPcsrc, 1'b1, 1'b0);
    nextCycle();
    checkAll({tag, ".fetch"}, 1'b1, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checkAll("reset", 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    nextCycle();
    checkAll("idle", 1'b1, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    runAlu("add",  I_ADD,  3'b000, 1'b0);
    runAlu("sub",  I_SUB,  3'b001, 1'b0);
    runAlu("slti", I_SLTI, 3'b101, 1'b1);
    runAlu("or",   I_OR,   3'b011, 1'b0);
    runAlu("andi", I_ANDI, 3'b010, 1'b1);

    runBranch("beq_eq1", I_BEQ, 1'b1, 1'b1);
    runBranch("beq_eq0", I_BEQ, 1'b0, 1'b0);
    runBranch("bne_eq1", I_BNE, 1'b1, 1'b0);
    runBranch("bne_eq0", I_BNE, 1'b0, 1'b1);

    // Wait states: an illegal word sits on the bus with valid low and must not be taken.
    applyStimulus(I_BAD, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput("wait.instr_ready", 32'(instr_ready), 32'd1);
      checkOutput("wait.PCen",        32'(PCen),        32'd0);
    end
    runAlu("sub_after_wait", I_SUB, 3'b001, 1'b0);

    applyStimulus(I_BAD, 1'b1, 1'b0);
    nextCycle();
    checkAll("bad.dec", 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkAll("bad.stuck", 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    rst = 1'b1;
    #1;
    checkOutput("bad.rst.illegal", 32'(illegal), 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0);
    #1;
    checkAll("bad.after_rst", 1'b1, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    runAlu("add_after_rst", I_ADD, 3'b000, 1'b0);

    // Reset arriving while WRITEBACK is on the outputs.
    applyStimulus(I_SUB, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(32'h0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("wbrst.pre.RegWrite", 32'(RegWrite), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("wbrst.RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("wbrst.PCen",     32'(PCen),     32'd0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("wbrst.fetch.instr_ready", 32'(instr_ready), 32'd1);
    checkOutput("wbrst.ir",                dut.ir_q,         32'h0);
    nextCycle();
    checkOutput("wbrst.hold.instr_ready",  32'(instr_ready), 32'd1);

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    checkOutput("retire_cnt.zero", retire_cnt, 32'd0);
`endif
    runAlu("cnt_add", I_ADD, 3'b000, 1'b0);
    runBranch("cnt_beq", I_BEQ, 1'b1, 1'b1);
    runAlu("cnt_andi", I_ANDI, 3'b010, 1'b1);
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    checkOutput("retire_cnt.three", retire_cnt, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer that drives the ALU datapath of the Lab-4 RISC-V core. It is the producer side of the ALU interface: it generates ALUctrl, ALUsrc, ImmSrc, RegWrite, PCsrc and PCen, and consumes the ALU EQ flag.
- Fetches each instruction from instruction memory over a valid/ready handshake, latches it into an internal IR, then steps FETCH -> DECODE -> EXECUTE/BRANCH -> WRITEBACK.
- Supports R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, and beq/bne.

Parameters:
- INSTR_WIDTH, 32, instruction word width. Must be 32; any other value is rejected by an elaboration-time assertion.
- CNT_WIDTH, 32, width of the retire counter (optional feature only).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  INSTR_WIDTH  instruction word from instruction memory.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  controller accepts instr this cycle.
- EQ  input  1  ALU equality flag: ALUop1 == ALUop2.
- ALUctrl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUsrc  output  1  0 selects register operand 2; 1 selects the immediate.
- ImmSrc  output  2  00 I-type immediate; 10 B-type immediate.
- RegWrite  output  1  register file write enable.
- PCsrc  output  1  0 selects PC+4; 1 selects PC+imm.
- PCen  output  1  PC register update enable.
- illegal  output  1  sticky flag: an illegal instruction has been decoded.

Behaviour:
- Reset: while rst=1 on a clock edge:
  - state <= FETCH, IR <= 0, illegal <= 0.
  - All outputs are 0 during the reset cycle, including instr_ready, which is gated by rst.
- Outputs are Moore-style: combinational from state and IR only. No output depends combinationally on instr or instr_valid.
- FETCH:
  - instr_ready = 1.
  - On instr_valid & instr_ready: IR <= instr, go to DECODE.
  - Otherwise stay in FETCH. Any number of wait cycles is allowed.
- DECODE (1 cycle), classified by opcode IR[6:0]:
  - 0110011 (R-type) and 0010011 (I-type) -> EXECUTE.
  - 1100011 with funct3 000 or 001 -> BRANCH.
  - Anything else -> ILLEGAL.
- R-type mapping:
  - funct3 000 with funct7[5]=0 -> add; funct7[5]=1 -> sub.
  - funct3 111 -> and; 110 -> or; 010 -> slt.
  - Any other funct3/funct7 combination is illegal.
- I-type mapping:
  - funct3 000 -> add; 111 -> and; 110 -> or; 010 -> slt.
  - Any other funct3 is illegal.
- EXECUTE (1 cycle):
  - Drive the decoded ALUctrl.
  - ALUsrc = 1 for I-type, 0 for R-type; ImmSrc = 00.
  - RegWrite = 0, PCen = 0. Go to WRITEBACK.
- WRITEBACK (1 cycle):
  - Hold ALUctrl, ALUsrc and ImmSrc from EXECUTE.
  - RegWrite = 1, PCen = 1, PCsrc = 0. Go to FETCH.
- BRANCH (1 cycle):
  - ALUctrl = 001 (sub), ALUsrc = 0, ImmSrc = 10, PCen = 1.
  - PCsrc = (beq & EQ) | (bne & ~EQ), sampled combinationally this cycle. Go to FETCH.
- ILLEGAL:
  - Terminal state. illegal = 1, instr_ready = 0, RegWrite = 0, PCen = 0.
  - Left only via rst.
- Latency:
  - ALU instruction: 4 cycles from handshake to next FETCH with zero wait.
  - Branch: 3 cycles.
  - Exactly one PCen pulse per retired instruction.
- Idle and inactive states:
  - In FETCH and DECODE: ALUctrl = 000, ALUsrc = 0, ImmSrc = 00, RegWrite = 0, PCsrc = 0, PCen = 0.
  - In every state, outputs not listed for that state are 0.
- instr_valid outside FETCH is ignored; the instruction is not latched.
- Reset asserted in any state, including mid-WRITEBACK, wins over all transitions. No RegWrite or PCen is asserted on that edge's cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_cnt [CNT_WIDTH-1:0].
  - Increments by 1 on every cycle with PCen = 1.
  - Wraps from all-ones to 0; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package ctrl_pkg holds:
  - alu_op_t enum: ADD=0, SUB=1, AND=2, OR=3, SLT=5.
  - Opcode constants OP_R, OP_I, OP_B.
  - Branch funct3 constants F3_BEQ, F3_BNE.
  - ImmSrc constants IMM_I, IMM_B.
  - ctrl_state_t enum: FETCH, DECODE, EXECUTE, BRANCH, WRITEBACK, ILLEGAL.
- Sub-module: instr_decoder, purely combinational.
  - Input: IR.
  - Outputs: alu_op, is_r, is_i, is_branch, is_bne, is_illegal.
- multicycle_ctrl contains the state register, IR and output logic.

Test Plan:
- Reset then add x1,x2,x3 (0x003100B3) with instr_valid held:
  - ALUctrl = 000, ALUsrc = 0 in EXECUTE.
  - RegWrite = PCen = 1 for exactly 1 cycle in WRITEBACK.
  - instr_ready back to 1 four cycles after the handshake.
- sub (0x403100B3) -> ALUctrl = 001. slti (0x0051A093) -> ALUctrl = 101, ALUsrc = 1, ImmSrc = 00.
- beq (0x00208463):
  - with EQ = 1 -> BRANCH cycle shows ALUctrl = 001, ImmSrc = 10, PCsrc = 1, PCen = 1, RegWrite = 0.
  - with EQ = 0 -> PCsrc = 0.
  - bne inverts both cases.
- instr_valid low for 5 cycles in FETCH -> instr_ready stays 1, PCen stays 0; the instruction is latched only on the first valid cycle.
- Opcode 0x0000007F -> illegal = 1 from the cycle after DECODE onward, instr_ready = 0 indefinitely; after rst, normal fetch resumes.
- rst asserted during WRITEBACK -> that cycle shows RegWrite = 0, PCen = 0; the next cycle is FETCH with IR = 0.
- With the macro defined, 3 instructions retired -> retire_cnt = 3.
